// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit and its helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int unsigned INST_BYTES_DEFAULT = 4;
    localparam logic [1:0]  ALIGN_MASK         = 2'b11;

    function automatic logic is_aligned(input logic [31:0] pc);
        return (pc[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect input and decode-side output.
interface instruction_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        misaligned_err;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_pc, inst_data, misaligned_err,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_pc, inst_data, misaligned_err,
        output inst_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_perf_counters.sv
// Free-running fetch/flush event counters, wrapping at 2^32.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_evt,
    input  logic        flush_evt,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
);

    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= 32'd0;
            flushed_q <= 32'd0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    always_comb begin
        fetched_d = fetched_q + {31'd0, fetch_evt};
        flushed_d = flushed_q + {31'd0, flush_evt};
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps one imem request in flight, handles redirects.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushed counter outputs.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned INST_BYTES = INST_BYTES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_flushed
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic [31:0]  inst_data_q, inst_data_d;
    logic         misaligned_q, misaligned_d;
    logic         redir_ok;

    assign redir_ok = bus.redirect_valid && is_aligned(bus.redirect_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            inst_pc_q    <= 32'd0;
            inst_data_q  <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            inst_pc_q    <= inst_pc_d;
            inst_data_q  <= inst_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        inst_pc_d    = inst_pc_q;
        inst_data_d  = inst_data_q;
        misaligned_d = bus.redirect_valid && !is_aligned(bus.redirect_pc);
        if (redir_ok) begin
            pc_d = bus.redirect_pc;
        end
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = WAIT;
                    // the request already left with the old PC; its response is stale
                    if (redir_ok) discard_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    discard_d = 1'b0;
                    state_d   = REQ;
                    if (!discard_q && !redir_ok) begin
                        inst_data_d = bus.imem_rsp_data;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + 32'(INST_BYTES);
                        state_d     = HOLD;
                    end
                end else if (redir_ok) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (redir_ok || bus.inst_ready) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = (state_q == REQ);
        bus.imem_req_addr  = pc_q;
        bus.inst_valid     = (state_q == HOLD);
        bus.inst_pc        = inst_pc_q;
        bus.inst_data      = inst_data_q;
        bus.misaligned_err = misaligned_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_evt;
    logic flush_evt;

    // a flush that coincides with inst_ready is counted as a consumed instruction
    always_comb begin
        fetch_evt = (state_q == HOLD) && bus.inst_ready;
        flush_evt = ((state_q == WAIT) && bus.imem_rsp_valid && (discard_q || redir_ok)) ||
                    ((state_q == HOLD) && redir_ok && !bus.inst_ready);
    end

    fetch_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_evt    (fetch_evt),
        .flush_evt    (flush_evt),
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a behavioural in-order imem model.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .INST_BYTES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_ipc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // imem: one response per accepted request, rsp_lat cycles after the handshake edge
    int          rsp_lat  = 1;
    int          rsp_cnt  = 0;
    logic [31:0] acc_addr = 32'd0;

    always @(posedge clk) begin
        #1;
        bus.imem_rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(acc_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                chk("req_q_nonempty", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) chk("req_addr", bus.imem_req_addr, exp_addr_q.pop_front());
                acc_addr = bus.imem_req_addr;
                rsp_cnt  = rsp_lat;
            end
            if (bus.inst_valid && bus.inst_ready) begin
                chk("inst_q_nonempty", 32'(exp_ipc_q.size() != 0), 32'd1);
                if (exp_ipc_q.size() != 0) begin
                    logic [31:0] p;
                    p = exp_ipc_q.pop_front();
                    chk("inst_pc", bus.inst_pc, p);
                    chk("inst_data", bus.inst_data, mem_word(p));
                end
            end
        end
    end

    task automatic wait_inst(input logic [31:0] pc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.inst_valid && bus.inst_pc == pc) begin
                found = 1'b1;
                break;
            end
        end
        chk($sformatf("wait_inst_%h", pc), {31'd0, found}, 32'd1);
    endtask

    task automatic wait_accept(input logic [31:0] addr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready && bus.imem_req_addr == addr) begin
                found = 1'b1;
                break;
            end
        end
        chk($sformatf("wait_accept_%h", addr), {31'd0, found}, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'd0);
        chk("rst_misaligned", {31'd0, bus.misaligned_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif
        // sequential zero-wait fetches; 0x8 is accepted but later discarded
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        exp_ipc_q.push_back(32'h0);  exp_ipc_q.push_back(32'h4);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_at_edge1", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("first_addr", bus.imem_req_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("inst_two_after_req", {31'd0, bus.inst_valid}, 32'd1);
        t0 = cyc;
        wait_inst(32'h4);
        chk("throughput", 32'(cyc - t0), 32'd3);

        // redirect in WAIT before the response arrives
        @(posedge clk); #1;
        rsp_lat = 2;
        exp_addr_q.push_back(32'h100);
        exp_ipc_q.push_back(32'h100);
        wait_accept(32'h8);
        pulse_redirect(32'h100);

        // flush in HOLD with decode stalled
        exp_addr_q.push_back(32'h104);
        wait_inst(32'h100);
        @(posedge clk); #1;
        bus.inst_ready = 1'b0;
        exp_addr_q.push_back(32'h40);
        exp_ipc_q.push_back(32'h40);
        wait_inst(32'h104);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        @(negedge clk);
        chk("flush_valid_low", {31'd0, bus.inst_valid}, 32'd0);

        // redirect while imem back-pressures the request
        exp_addr_q.push_back(32'h200);
        exp_ipc_q.push_back(32'h200);
        wait_inst(32'h40);
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        chk("stall_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("stall_addr", bus.imem_req_addr, 32'h44);
        repeat (4) @(posedge clk);
        pulse_redirect(32'h200);
        @(negedge clk);
        chk("redir_in_req_addr", bus.imem_req_addr, 32'h200);
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b1;

        // misaligned redirect is ignored apart from a one-cycle error pulse
        exp_addr_q.push_back(32'h204); exp_addr_q.push_back(32'h208);
        exp_ipc_q.push_back(32'h204);  exp_ipc_q.push_back(32'h208);
        wait_inst(32'h200);
        pulse_redirect(32'h102);
        @(negedge clk);
        chk("misaligned_hi", {31'd0, bus.misaligned_err}, 32'd1);
        @(negedge clk);
        chk("misaligned_lo", {31'd0, bus.misaligned_err}, 32'd0);

        // redirect landing on a same-cycle handshake, then PC wrap
        exp_addr_q.push_back(32'h20C);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_ipc_q.push_back(32'hFFFF_FFFC);
        exp_ipc_q.push_back(32'h0);
        wait_inst(32'h208);
        pulse_redirect(32'hFFFF_FFFC);
        wait_inst(32'h0);
        @(posedge clk); #1;
        bus.inst_ready = 1'b0;
        wait_inst(32'h4);
        chk("inst_data_hold", bus.inst_data, mem_word(32'h4));
        chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("inst_q_drained", 32'(exp_ipc_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd9);
        chk("perf_flushed", perf_flushed, 32'd3);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
